// File: rtl/byte_striping_pkg.sv
// ---------------------------------------------------------------------------
// byte_striping_pkg
// Shared constants and types for the byte striping block.
//   DATA_W_DEF   : default word / lane width in bits
//   NUM_LANES    : number of output lanes
//   lane_idx_t   : 1-bit lane index
//   REALIGN_IDLE : idle run length that forces the next word onto lane 0
//                  (used only when BYTE_STRIPING_REALIGN_EN is defined)
// ---------------------------------------------------------------------------
package byte_striping_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_LANES    = 2;
    localparam int REALIGN_IDLE = 2;

    typedef logic [0:0] lane_idx_t;
    typedef logic [1:0] idle_cnt_t;

endpackage : byte_striping_pkg

// File: rtl/byte_striping_if.sv
// ---------------------------------------------------------------------------
// byte_striping_if
// Groups the input word stream and the two lane outputs of byte_striping.
//   valid_in / data_in        : input word stream (driven by the source)
//   valid_0 / lane_0          : lane 0 word, even-indexed words
//   valid_1 / lane_1          : lane 1 word, odd-indexed words
//   lane_sel                  : lane that receives the next valid word
// Modports:
//   master : word source / observer (drives the stream, reads the lanes)
//   slave  : the striper itself
// ---------------------------------------------------------------------------
interface byte_striping_if
    import byte_striping_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic              valid_0;
    logic [DATA_W-1:0] lane_0;
    logic              valid_1;
    logic [DATA_W-1:0] lane_1;
    logic              lane_sel;

    modport master (
        output valid_in, data_in,
        input  valid_0, lane_0, valid_1, lane_1, lane_sel
    );

    modport slave (
        input  valid_in, data_in,
        output valid_0, lane_0, valid_1, lane_1, lane_sel
    );

endinterface : byte_striping_if

// File: rtl/stripe_lane_reg.sv
// ---------------------------------------------------------------------------
// stripe_lane_reg
// One output lane: data register, valid flag and a 1-bit hold counter.
// A write keeps the valid flag high for exactly two clk_2f cycles so a
// half-rate consumer always gets one clean sampling opportunity.
//   clk_2f  : fast clock
//   reset   : asynchronous, active-high
//   wr_en   : load wr_data into this lane this cycle
//   wr_data : word to load
//   valid   : data holds a live word
//   data    : lane word (kept after valid drops; cleared only by reset)
// ---------------------------------------------------------------------------
module stripe_lane_reg
    import byte_striping_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic hold;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
            hold  <= 1'b0;
        end else if (wr_en) begin
            // A write overrides an expiring hold on the same lane.
            data  <= wr_data;
            valid <= 1'b1;
            hold  <= 1'b1;
        end else if (hold) begin
            hold  <= 1'b0;          // second cycle of the word: valid stays 1
        end else begin
            valid <= 1'b0;          // data is left as a stale, invalid word
        end
    end

endmodule : stripe_lane_reg

// File: rtl/byte_striping.sv
// ---------------------------------------------------------------------------
// byte_striping
// Distributes consecutive valid words of one clk_2f stream alternately onto
// two lanes, lane 0 first. Each lane word stays valid for two clk_2f cycles.
//   clk_2f : fast clock, all logic on its rising edge
//   reset  : asynchronous, active-high
//   bus    : byte_striping_if.slave (valid_in/data_in in; valid_0/lane_0,
//            valid_1/lane_1, lane_sel out)
// Configuration macro: BYTE_STRIPING_REALIGN_EN
//   defined   -> two or more consecutive idle cycles force the next word
//                onto lane 0
//   undefined -> alternation continues across gaps
// ---------------------------------------------------------------------------
module byte_striping
    import byte_striping_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic            clk_2f,
    input  logic            reset,
    byte_striping_if.slave  bus
);

    lane_idx_t lane_sel;
    lane_idx_t lane_sel_nxt;
    logic      wr_en_0;
    logic      wr_en_1;

`ifdef BYTE_STRIPING_REALIGN_EN
    idle_cnt_t idle_cnt;
    idle_cnt_t idle_cnt_nxt;

    // Counts consecutive idle cycles, saturating at REALIGN_IDLE.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        idle_cnt_nxt = idle_cnt;
        if (bus.valid_in) begin
            idle_cnt_nxt = '0;
        end else if (idle_cnt != idle_cnt_t'(REALIGN_IDLE)) begin
            idle_cnt_nxt = idle_cnt + idle_cnt_t'(1);
        end
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt_nxt;
        end
    end
`endif

    always_comb begin
        lane_sel_nxt = lane_sel;
        if (bus.valid_in) begin
            lane_sel_nxt = ~lane_sel;
        end
`ifdef BYTE_STRIPING_REALIGN_EN
        else if (idle_cnt_nxt == idle_cnt_t'(REALIGN_IDLE)) begin
            lane_sel_nxt = lane_idx_t'(0);
        end
`endif
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            lane_sel <= lane_idx_t'(0);
        end else begin
            lane_sel <= lane_sel_nxt;
        end
    end

    assign wr_en_0 = bus.valid_in & (lane_sel == lane_idx_t'(0));
    assign wr_en_1 = bus.valid_in & (lane_sel == lane_idx_t'(1));

    stripe_lane_reg #(.DATA_W(DATA_W)) u_lane_0 (
        .clk_2f  (clk_2f),
        .reset   (reset),
        .wr_en   (wr_en_0),
        .wr_data (bus.data_in),
        .valid   (bus.valid_0),
        .data    (bus.lane_0)
    );

    stripe_lane_reg #(.DATA_W(DATA_W)) u_lane_1 (
        .clk_2f  (clk_2f),
        .reset   (reset),
        .wr_en   (wr_en_1),
        .wr_data (bus.data_in),
        .valid   (bus.valid_1),
        .data    (bus.lane_1)
    );

    assign bus.lane_sel = lane_sel;

endmodule : byte_striping

// File: tb/tb_byte_striping.sv
// ---------------------------------------------------------------------------
// tb_byte_striping
// Self-checking bench for byte_striping. The reference model tracks the
// ordinal of each accepted word (even -> lane 0, odd -> lane 1), the cycle in
// which each lane was last written, and the current idle run length. A lane
// is expected valid in the cycle of its write and the one after.
// ---------------------------------------------------------------------------
module tb_byte_striping;

    import byte_striping_pkg::*;

    localparam int W = DATA_W_DEF;

    logic clk_2f;
    logic reset;

    byte_striping_if #(.DATA_W(W)) bus ();

    byte_striping #(.DATA_W(W)) dut (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    // ------------------------------------------------------------------
    // Scoreboard counters
    // ------------------------------------------------------------------
    int vectors     = 0;
    int miscompares = 0;

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    int          cyc;
    int          last_wr[2];
    logic [W-1:0] exp_word[2];
    int          word_ord;     // ordinal of next accepted word since alignment
    int          idle_run;

    task automatic model_reset();
        cyc         = 0;
        last_wr[0]  = -100;
        last_wr[1]  = -100;
        exp_word[0] = '0;
        exp_word[1] = '0;
        word_ord    = 0;
        idle_run    = 0;
    endtask

    task automatic model_edge(input logic v, input logic [W-1:0] d);
        int lane;
        cyc++;
        if (v) begin
            lane           = word_ord % 2;
            exp_word[lane] = d;
            last_wr[lane]  = cyc;
            word_ord++;
            idle_run = 0;
        end else begin
            idle_run++;
`ifdef BYTE_STRIPING_REALIGN_EN
            if (idle_run >= REALIGN_IDLE) word_ord = 0;
`endif
        end
    endtask

    function automatic logic exp_valid(input int lane);
        return (cyc - last_wr[lane]) <= 1;
    endfunction

    // ------------------------------------------------------------------
    // Comparison helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [W-1:0] observed,
                         input logic [W-1:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".valid_0"},  W'(bus.valid_0),  W'(exp_valid(0)));
        check({ctx, ".lane_0"},   bus.lane_0,       exp_word[0]);
        check({ctx, ".valid_1"},  W'(bus.valid_1),  W'(exp_valid(1)));
        check({ctx, ".lane_1"},   bus.lane_1,       exp_word[1]);
        check({ctx, ".lane_sel"}, W'(bus.lane_sel), W'(word_ord % 2));
    endtask

    // Drive one cycle from a falling edge, update the model on the rising
    // edge, check on the following falling edge.
    task automatic step(input logic v, input logic [W-1:0] d, input string ctx);
        bus.valid_in = v;
        bus.data_in  = d;
        @(posedge clk_2f);
        model_edge(v, d);
        @(negedge clk_2f);
        check_all(ctx);
    endtask

    task automatic idle(input int n, input string ctx);
        for (int i = 0; i < n; i++) step(1'b0, 32'hDEADBEEF, ctx);
    endtask

    task automatic do_reset(input string ctx);
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        reset        = 1'b1;
        model_reset();
        #1;
        check_all({ctx, ".async"});
        @(posedge clk_2f);
        @(negedge clk_2f);
        check_all({ctx, ".held"});
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [W-1:0] rnd;
    int           exp_lane_4;

    initial begin
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        model_reset();
        @(negedge clk_2f);
        check_all("por");
        reset = 1'b0;

        // Idle after reset: everything stays cleared.
        idle(3, "idle_after_reset");

        // Continuous stream.
        step(1'b1, 32'hFFFFFFFF, "stream");
        step(1'b1, 32'h88888888, "stream");
        step(1'b1, 32'h77777777, "stream");
        step(1'b1, 32'h55555555, "stream");
        check("stream.lane_0_final", bus.lane_0, 32'h77777777);
        check("stream.lane_1_final", bus.lane_1, 32'h55555555);
        idle(3, "stream_drain");

        // Single word.
        do_reset("rst_single");
        step(1'b1, 32'hAAAAAAAA, "single");
        check("single.lane_0", bus.lane_0, 32'hAAAAAAAA);
        idle(3, "single_tail");
        check("single.lane_sel_end", W'(bus.lane_sel), W'(1));
        check("single.valid_1_end", W'(bus.valid_1), W'(0));

        // Three words, long gap, one more word.
        do_reset("rst_gap3");
        step(1'b1, 32'h11111111, "gap3");
        step(1'b1, 32'h22222222, "gap3");
        step(1'b1, 32'h33333333, "gap3");
        idle(3, "gap3_idle");
        step(1'b1, 32'h44444444, "gap3_last");
`ifdef BYTE_STRIPING_REALIGN_EN
        exp_lane_4 = 0;
`else
        exp_lane_4 = 1;
`endif
        check("gap3.word4_lane", (exp_lane_4 == 0) ? bus.lane_0 : bus.lane_1,
              32'h44444444);
        idle(2, "gap3_tail");

        // One idle cycle never realigns.
        do_reset("rst_gap1");
        step(1'b1, 32'h11111111, "gap1");
        idle(1, "gap1_idle");
        step(1'b1, 32'h22222222, "gap1_last");
        check("gap1.word2_lane_1", bus.lane_1, 32'h22222222);
        idle(3, "gap1_tail");

        // Reset asserted mid-stream.
        step(1'b1, 32'hCAFEF00D, "pre_mid_rst");
        step(1'b1, 32'h0BADCAFE, "pre_mid_rst");
        do_reset("rst_mid");
        step(1'b1, 32'h12345678, "post_mid_rst");
        check("post_mid_rst.lane_0", bus.lane_0, 32'h12345678);

        // Randomized traffic; idle cycles carry garbage data.
        for (int i = 0; i < 300; i++) begin
            rnd = $urandom;
            if ($urandom_range(9, 0) < 6) step(1'b1, rnd, "rand");
            else                          step(1'b0, 32'hDEADBEEF, "rand_idle");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog: the sequence is finite, but never let the run hang.
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_byte_striping

// File: doc/byte_striping.md
# byte_striping

Transmit-side counterpart of the byte un-striping block. Consumes one 32-bit word stream at the fast clock (`clk_2f`) and distributes consecutive valid words alternately onto two lanes, lane 0 first. Each lane output presents a word long enough for a half-rate consumer to sample it. Sits between the packet source and the two-lane physical path; its lane outputs drive the un-striper's `lane_0`/`valid_0` and `lane_1`/`valid_1` inputs.

## Interface
- `DATA_W`, 32, word and lane width in bits
- `clk_2f`  input  1  fast clock; all logic on its rising edge
- `reset`  input  1  asynchronous, active-high; clears all state immediately
- `valid_in`  input  1  `data_in` carries a word this cycle
- `data_in`  input  DATA_W  input word
- `valid_0`  output  1  `lane_0` holds a live word
- `lane_0`  output  DATA_W  lane 0 word (even-indexed words)
- `valid_1`  output  1  `lane_1` holds a live word
- `lane_1`  output  DATA_W  lane 1 word (odd-indexed words)
- `lane_sel`  output  1  lane that will receive the next valid word (0/1)

## Operation
- Reset values:
  - `lane_0` = `lane_1` = 0
  - `valid_0` = `valid_1` = 0
  - `lane_sel` = 0
  - both hold counters = 0
- Valid word with `lane_sel`=0:
  - `lane_0` <= `data_in`, `valid_0` <= 1, hold_0 <= 1, `lane_sel` <= 1.
- Valid word with `lane_sel`=1:
  - `lane_1` <= `data_in`, `valid_1` <= 1, hold_1 <= 1, `lane_sel` <= 0.
- `valid_in`=0: no write and `lane_sel` unchanged, except under the `Configuration` option.
- Per-lane hold, for a lane that is not written this cycle:
  - hold_x=1: hold_x <= 0 and `valid_x` stays 1.
  - hold_x=0: `valid_x` <= 0.
  - Net effect: a single write keeps `valid_x` high for exactly 2 cycles.
- Lane data registers are never cleared except by reset. A stale word stays visible with `valid_x`=0.
- Continuous stream: each lane is written every 2nd cycle, so `valid_0` and `valid_1` stay high for the whole stream.
- `data_in` is ignored whenever `valid_in`=0 (X-tolerant).
- No backpressure: every valid word is accepted.

## Timing
- Latency: `data_in` sampled at edge t appears on its lane after edge t, i.e. from cycle t+1.
- Lane outputs are registered; no combinational path from inputs to outputs.
- Lane 0 and lane 1 are skewed by one `clk_2f` cycle. Both lanes are simultaneously stable for the cycle after every odd-indexed write, which is the half-rate sampling window.
- Asynchronous reset asserted mid-stream: all outputs go to reset values at once. The first valid word after release goes to lane 0.
- Simultaneous write and hold expiry on the same lane: the write wins (`valid_x`=1, hold_x=1).

## Configuration
- `BYTE_STRIPING_REALIGN_EN`
  - Defined: a 2-bit idle counter counts consecutive `valid_in`=0 cycles, saturating at 2. On reaching 2, `lane_sel` <= 0, so every burst that follows a gap of ≥2 idle cycles starts on lane 0. The counter clears on any valid word.
  - Undefined: `lane_sel` changes only on valid words or reset, so alternation continues across gaps. No idle counter is built.

## Structure
- Package `byte_striping_pkg`:
  - `DATA_W_DEF`=32
  - `NUM_LANES`=2
  - `lane_idx_t` (1-bit lane index type)
  - `REALIGN_IDLE`=2
- Sub-module `stripe_lane_reg`: one lane's data register, valid flag and hold counter; inputs `wr_en` and `wr_data`. Instantiated twice, with `wr_en` = `valid_in` & (`lane_sel` == index).
- Top level holds `lane_sel`, and the idle counter when `BYTE_STRIPING_REALIGN_EN` is defined.

## Test plan
- Reset, then idle → all outputs 0, `lane_sel`=0. Assert `reset` mid-stream → outputs 0 asynchronously, before the next edge.
- Continuous words FFFFFFFF, 88888888, 77777777, 55555555 → `lane_0`: FFFFFFFF then 77777777; `lane_1`: 88888888 then 55555555. `valid_0` and `valid_1` stay high until 2 cycles after each lane's last write.
- Single word AAAAAAAA → `lane_0`=AAAAAAAA with `valid_0` high for exactly 2 cycles, `valid_1` stays 0, `lane_sel` ends at 1.
- Words 11111111, 22222222, 33333333, then 3 idle cycles, then 44444444:
  - Without the macro: 44444444 goes to `lane_1`.
  - With `BYTE_STRIPING_REALIGN_EN`: 44444444 goes to `lane_0`.
- Words 11111111, then 1 idle cycle, then 22222222 (both builds) → 22222222 goes to `lane_1` (one idle cycle does not realign).
- Invalid cycles carry garbage `data_in`=DEADBEEF → no lane register changes; previous lane values persist.
